note_sequencer: RTL
===================

# note_sequencer

Record/playback controller for the electric piano. It encodes the debounced note switches and octave into a live note and writes each new note into the external note buffer. On a playback toggle it reads the buffer back one entry per step tick. It sits between the debounced input block and the note buffer, and drives the tone generator's note input.

## Interface
- DEPTH, 64: note buffer capacity in entries (power of two).
- AW, 6: buffer address width, log2(DEPTH).
- clk  in  1  system clock (100 MHz); every input is synchronous to it except rst.
- rst  in  1  asynchronous, active-high reset.
- note_switches  in  7  debounced levels; bit0=C … bit6=B.
- toggle_pb  in  1  one-cycle pulse: enter or leave playback.
- inc_octave, dec_octave  in  1 each  one-cycle pulses.
- clr  in  1  one-cycle pulse: discard the recording.
- step_tick  in  1  one-cycle playback tempo strobe (for example 4 Hz).
- buf_add  out  1  buffer write enable.
- buf_addr  out  AW  buffer address, shared by reads and writes.
- buf_wdata  out  6  buffer write data.
- buf_rd  out  1  buffer read enable; buf_rdata is valid the cycle after buf_rd.
- buf_rdata  in  6  buffer read data.
- note_out  out  6  current note {octave[2:0], tone[2:0]}; tone 0 = rest, 1..7 = C..B.
- pb_mode  out  1  high while in playback.
- rec_full  out  1  high when length == DEPTH.
- length  out  AW+1  number of recorded notes.

## Operation
- Octave register: 3 bits, reset value 4.
  - inc_octave increments it and saturates at 7.
  - dec_octave decrements it and saturates at 0.
  - Both pulses in the same cycle: no change.
  - Pulses are honoured in every state; the octave only affects live notes.
- Live encode: tone = 1 + index of the lowest set switch bit, or 0 if no bit is set. live_note = {octave, tone}.
- States: LIVE, PB_FETCH, PB_WAIT, PB_HOLD.
- LIVE:
  - note_out = live_note.
  - When live_note differs from its previous-cycle value, tone != 0 and length < DEPTH:
    - buf_add=1, buf_addr=length[AW-1:0], buf_wdata=live_note, for one cycle.
    - length increments.
  - Rests are never recorded.
  - When the buffer is full, writes are dropped silently.
- toggle_pb in LIVE:
  - length == 0: ignored.
  - Otherwise: ptr=0, go to PB_FETCH. No write is made in that cycle, even if the note changed.
- PB_FETCH: buf_rd=1, buf_addr=ptr, note_out held from the previous state; go to PB_WAIT.
- PB_WAIT: latch buf_rdata into note_out; go to PB_HOLD.
- PB_HOLD: on step_tick:
  - ptr == length-1: go to LIVE.
  - Otherwise: ptr++ and go to PB_FETCH.
- step_tick is ignored in PB_FETCH and PB_WAIT.
- toggle_pb in any PB_* state: go to LIVE next cycle. length is kept and no read is issued.
- clr in any state: length=0, ptr=0, go to LIVE. clr has priority over toggle_pb, writes and ticks in the same cycle.
- pb_mode = 1 in PB_FETCH, PB_WAIT and PB_HOLD.
- rec_full = (length == DEPTH).
- buf_add and buf_rd are never high in the same cycle.

## Timing
- Reset values:
  - State LIVE, octave 4, length 0, ptr 0.
  - note_out = {3'd4, 3'd0}; the previous-live-note register holds the same value.
  - buf_add=0, buf_rd=0, buf_addr=0, buf_wdata=0, pb_mode=0, rec_full=0.
- All outputs are registered.
- Live path:
  - note_out follows a switch change 1 cycle later.
  - buf_add is asserted in that same cycle.
  - length updates the cycle after buf_add.
- Playback path:
  - toggle_pb in cycle t gives PB_FETCH at t+1 (buf_rd=1) and the first note on note_out at t+3.
  - Each subsequent note appears 3 cycles after the step_tick that advanced ptr.
- Exit: note_out returns to live_note 1 cycle after entering LIVE.
- Reset mid-playback or mid-write: all state returns to reset values immediately; a write already in flight is not completed.

## Test plan
- Reset, then press SW_E: note_out = 0x23 the next cycle; one buf_add with addr 0, wdata 0x23; length = 1.
- Press inc_octave 5 times, then dec_octave and inc_octave in the same cycle: octave saturates at 7 and then stays 7; pressing SW_C then gives note_out = 0x39.
- Record C, D, G at octave 4 (0x21, 0x22, 0x25), pulse toggle_pb, then issue step_tick every 20 cycles:
  - buf_rd at addresses 0, 1, 2; note_out sequence 0x21, 0x22, 0x25.
  - After the third tick, pb_mode falls and note_out = live_note.
- Write 64 distinct-transition notes, then a 65th: rec_full=1, length=64, no buf_add for the 65th.
- toggle_pb with length 0: pb_mode stays 0 and buf_rd is never asserted.
- During PB_HOLD, clr and toggle_pb in the same cycle: next cycle state LIVE, length 0, no buf_rd; a later toggle_pb is ignored.

Source files
------------

// File: rtl/note_sequencer.sv
// Record/playback controller: encodes live notes into the note buffer and replays them one per step tick.
// All outputs registered; a buffer read returns data the cycle after buf_rd.
module note_sequencer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    note_switches,
  input  logic          toggle_pb,
  input  logic          inc_octave,
  input  logic          dec_octave,
  input  logic          clr,
  input  logic          step_tick,
  output logic          buf_add,
  output logic [AW-1:0] buf_addr,
  output logic [5:0]    buf_wdata,
  output logic          buf_rd,
  input  logic [5:0]    buf_rdata,
  output logic [5:0]    note_out,
  output logic          pb_mode,
  output logic          rec_full,
  output logic [AW:0]   length
);

  typedef enum logic [1:0] {LIVE, PB_FETCH, PB_WAIT, PB_HOLD} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state_q;
  logic [2:0]    octave_q, octave_d;
  logic [AW:0]   count_q;
  logic [AW:0]   length_q;
  logic [AW-1:0] ptr_q;
  logic [5:0]    note_q, prev_live_q;
  logic          buf_add_q, buf_rd_q, pb_mode_q, rec_full_q;
  logic [AW-1:0] buf_addr_q;
  logic [5:0]    buf_wdata_q;
  logic [2:0]    tone;
  logic [5:0]    live_note;
  logic          rec_ok;

  always_comb begin
    tone = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (note_switches[i]) tone = 3'(i + 1);
    end
  end

  always_comb begin
    octave_d = octave_q;
    if (inc_octave && !dec_octave && octave_q != 3'd7) octave_d = octave_q + 3'd1;
    if (dec_octave && !inc_octave && octave_q != 3'd0) octave_d = octave_q - 3'd1;
  end

  assign live_note = {octave_q, tone};
  // count_q runs one cycle ahead of length_q so back-to-back writes get distinct addresses
  assign rec_ok = (live_note != prev_live_q) && (tone != 3'd0) && (count_q != FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LIVE;
      octave_q    <= 3'd4;
      count_q     <= '0;
      length_q    <= '0;
      ptr_q       <= '0;
      note_q      <= 6'h20;
      prev_live_q <= 6'h20;
      buf_add_q   <= 1'b0;
      buf_rd_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      pb_mode_q   <= 1'b0;
      rec_full_q  <= 1'b0;
    end else begin
      buf_add_q   <= 1'b0;
      buf_rd_q    <= 1'b0;
      prev_live_q <= live_note;
      octave_q    <= octave_d;
      length_q    <= count_q;
      rec_full_q  <= (count_q == FULL);
      if (clr) begin
        state_q    <= LIVE;
        pb_mode_q  <= 1'b0;
        count_q    <= '0;
        length_q   <= '0;
        rec_full_q <= 1'b0;
        ptr_q      <= '0;
        if (state_q == LIVE) note_q <= live_note;
      end else begin
        case (state_q)
          LIVE: begin
            note_q <= live_note;
            if (toggle_pb && count_q != '0) begin
              ptr_q      <= '0;
              buf_rd_q   <= 1'b1;
              buf_addr_q <= '0;
              pb_mode_q  <= 1'b1;
              state_q    <= PB_FETCH;
            end else if (rec_ok) begin
              buf_add_q   <= 1'b1;
              buf_addr_q  <= count_q[AW-1:0];
              buf_wdata_q <= live_note;
              count_q     <= count_q + 1'b1;
            end
          end
          PB_FETCH: begin
            if (toggle_pb) begin
              state_q   <= LIVE;
              pb_mode_q <= 1'b0;
            end else begin
              state_q <= PB_WAIT;
            end
          end
          PB_WAIT: begin
            if (toggle_pb) begin
              state_q   <= LIVE;
              pb_mode_q <= 1'b0;
            end else begin
              note_q  <= buf_rdata;
              state_q <= PB_HOLD;
            end
          end
          PB_HOLD: begin
            if (toggle_pb || (step_tick && {1'b0, ptr_q} == count_q - 1'b1)) begin
              state_q   <= LIVE;
              pb_mode_q <= 1'b0;
            end else if (step_tick) begin
              ptr_q      <= ptr_q + 1'b1;
              buf_rd_q   <= 1'b1;
              buf_addr_q <= ptr_q + 1'b1;
              state_q    <= PB_FETCH;
            end
          end
          default: state_q <= LIVE;
        endcase
      end
    end
  end

  assign buf_add   = buf_add_q;
  assign buf_addr  = buf_addr_q;
  assign buf_wdata = buf_wdata_q;
  assign buf_rd    = buf_rd_q;
  assign note_out  = note_q;
  assign pb_mode   = pb_mode_q;
  assign rec_full  = rec_full_q;
  assign length    = length_q;

endmodule
